// File: rtl/prbs7_pkg.sv
// rtl/prbs7_pkg.sv - shared PRBS7 (x^7+x^6+1) constants, FSM type and bit-step helpers
//
// Contents:
//   PRBS7_LEN           polynomial degree / state width (7)
//   PRBS7_DEFAULT_SEED  all-ones seed, also the substitute for an illegal zero seed
//   gen_state_t         generator FSM encoding (IDLE / RUN)
//   prbs7_step()        advance a 7-bit state by one output bit
//   prbs7_seed_fix()    map the lock-up seed 7'h00 onto the default seed
//
// The state holds the seven most recent stream bits with the newest bit in [6]
// and the oldest in [0]. The step function is also used by checker-side code,
// so the bit ordering here is the link-wide definition.

package prbs7_pkg;

    localparam int         PRBS7_LEN          = 7;
    localparam logic [6:0] PRBS7_DEFAULT_SEED = 7'h7F;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_t;

    // Next bit is b[n-6]^b[n-7] (state[1]^state[0]); it enters at the top
    // and becomes the new state[6], so the emitted bit is the result's [6].
    function automatic logic [6:0] prbs7_step(input logic [6:0] state);
        return {state[1] ^ state[0], state[6:1]};
    endfunction

    // An all-zero state would lock the LFSR at zero forever.
    function automatic logic [6:0] prbs7_seed_fix(input logic [6:0] seed);
        return (seed == 7'h00) ? PRBS7_DEFAULT_SEED : seed;
    endfunction

endpackage

// File: rtl/prbs7_gen_if.sv
// rtl/prbs7_gen_if.sv - control/data bundle between a PRBS7 word generator and its user
//
// Signals (direction seen from the generator / slave side):
//   en          in   advance generator and emit a word this cycle
//   seed_load   in   load seed_in into the generator state (wins over en)
//   seed_in     in   new seed; 7'h00 is replaced by 7'h7F
//   inj_req     in   request a single-bit error on the next emitted word
//   inj_bit     in   bit index to flip
//   dout        out  PRBS7 word
//   dout_valid  out  dout updated this cycle
//   word_cnt    out  emitted words, wraps at 16 bits
//   inj_ack     out  pulses with the dout_valid of the corrupted word
//
// Macro PRBS7GEN_ERRINJ_EN: when defined, the inj_req/inj_bit/inj_ack signals
// and their modport entries exist; otherwise they are absent.
//
// Modports: master drives the controls and observes the words; slave is the
// generator.

interface prbs7_gen_if #(
    parameter int WORDWIDTH = 16
);

    localparam int IBW = $clog2(WORDWIDTH);

    logic                 en;
    logic                 seed_load;
    logic [6:0]           seed_in;
    logic [WORDWIDTH-1:0] dout;
    logic                 dout_valid;
    logic [15:0]          word_cnt;
`ifdef PRBS7GEN_ERRINJ_EN
    logic                 inj_req;
    logic [IBW-1:0]       inj_bit;
    logic                 inj_ack;
`endif

`ifdef PRBS7GEN_ERRINJ_EN
    modport master (
        output en, seed_load, seed_in, inj_req, inj_bit,
        input  dout, dout_valid, word_cnt, inj_ack
    );

    modport slave (
        input  en, seed_load, seed_in, inj_req, inj_bit,
        output dout, dout_valid, word_cnt, inj_ack
    );
`else
    modport master (
        output en, seed_load, seed_in,
        input  dout, dout_valid, word_cnt
    );

    modport slave (
        input  en, seed_load, seed_in,
        output dout, dout_valid, word_cnt
    );
`endif

endinterface

// File: rtl/prbs7_word_comb.sv
// rtl/prbs7_word_comb.sv - combinational PRBS7 state -> {WORDWIDTH-bit word, next state}
//
// Parameters:
//   WORDWIDTH   output word width, 7..64
// Ports:
//   state       in   seven most recent stream bits (newest in [6])
//   word        out  next WORDWIDTH stream bits, first-generated bit in [0]
//   next_state  out  state after the word; equals word[W-1:W-7]
//
// The loop unrolls into a WORDWIDTH-deep XOR network; each output bit is an
// XOR of at most a few state bits, so depth stays small for W <= 64.

module prbs7_word_comb
    import prbs7_pkg::*;
#(
    parameter int WORDWIDTH = 16
) (
    input  logic [6:0]           state,
    output logic [WORDWIDTH-1:0] word,
    output logic [6:0]           next_state
);

    logic [6:0] c;

    always_comb begin
        c    = state;
        word = '0;
        for (int i = 0; i < WORDWIDTH; i++) begin
            c       = prbs7_step(c);
            word[i] = c[6];
        end
        next_state = c;
    end

endmodule

// File: rtl/prbs7_gen.sv
// rtl/prbs7_gen.sv - parallel PRBS7 (x^7+x^6+1) word generator for readout-link test mode
//
// Parameters:
//   WORDWIDTH   output word width, 7..64
//   SEED        state loaded at reset, must be nonzero
// Ports:
//   clk         word clock
//   rstn        asynchronous active-low reset
//   bus         prbs7_gen_if slave: en, seed_load, seed_in, dout, dout_valid,
//               word_cnt (+ inj_req, inj_bit, inj_ack with the macro)
//
// Macro PRBS7GEN_ERRINJ_EN: when defined, single-bit error injection is built
// (pending flag, captured bit index, inj_ack pulse). When undefined dout is
// always the clean PRBS7 word.
//
// All outputs are registered: a word appears one clk after the edge that
// sampled en=1. The generator state always advances from the clean word, so an
// injected error never shifts the sequence.

module prbs7_gen
    import prbs7_pkg::*;
#(
    parameter int         WORDWIDTH = 16,
    parameter logic [6:0] SEED      = PRBS7_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rstn,
    prbs7_gen_if.slave  bus
);

    localparam int IBW = $clog2(WORDWIDTH);

    gen_state_t           st;
    logic [6:0]           s;
    logic [6:0]           s_next;
    logic [WORDWIDTH-1:0] word_clean;
    logic [WORDWIDTH-1:0] inj_mask;
    logic [WORDWIDTH-1:0] dout_q;
    logic [15:0]          cnt_q;
    logic                 emit;

    prbs7_word_comb #(
        .WORDWIDTH (WORDWIDTH)
    ) u_word (
        .state      (s),
        .word       (word_clean),
        .next_state (s_next)
    );

    // seed_load takes the cycle: no word is emitted even with en=1.
    assign emit = bus.en && !bus.seed_load;

`ifdef PRBS7GEN_ERRINJ_EN
    logic           inj_pend;
    logic [IBW-1:0] inj_bit_q;
    logic           inj_ack_q;
    logic           inj_bit_ok;

    // Decode by equality against each legal index so an out-of-range request
    // (only possible when WORDWIDTH is not a power of two) is simply dropped.
    always_comb begin
        inj_bit_ok = 1'b0;
        inj_mask   = '0;
        for (int i = 0; i < WORDWIDTH; i++) begin
            if (bus.inj_bit == IBW'(i)) begin
                inj_bit_ok = 1'b1;
            end
            if (inj_bit_q == IBW'(i)) begin
                inj_mask[i] = inj_pend;
            end
        end
    end

    assign bus.inj_ack = inj_ack_q;
`else
    assign inj_mask = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st     <= ST_IDLE;
            s      <= SEED;
            dout_q <= '0;
            cnt_q  <= '0;
`ifdef PRBS7GEN_ERRINJ_EN
            inj_pend  <= 1'b0;
            inj_bit_q <= '0;
            inj_ack_q <= 1'b0;
`endif
        end else begin
            if (bus.seed_load) begin
                st <= ST_IDLE;
                s  <= prbs7_seed_fix(bus.seed_in);
            end else if (bus.en) begin
                st     <= ST_RUN;
                s      <= s_next;
                dout_q <= word_clean ^ inj_mask;
                cnt_q  <= cnt_q + 16'd1;
            end else begin
                st <= ST_IDLE;
            end

`ifdef PRBS7GEN_ERRINJ_EN
            // A request arriving on an emitting cycle is not applied to the
            // word being emitted now; the pending flag it sets is seen by the
            // next emitting cycle. Requests while pending are ignored.
            inj_ack_q <= 1'b0;
            if (emit && inj_pend) begin
                inj_pend  <= 1'b0;
                inj_ack_q <= 1'b1;
            end else if (!inj_pend && bus.inj_req && inj_bit_ok) begin
                inj_pend  <= 1'b1;
                inj_bit_q <= bus.inj_bit;
            end
`endif
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = (st == ST_RUN);
    assign bus.word_cnt   = cnt_q;

    // emit mirrors the priority chain above; only the injection logic needs it
    // as a separate net, so keep it referenced in the default build too.
    logic unused_emit;
    assign unused_emit = emit;

endmodule

// File: tb/tb_prbs7_gen.sv
// tb/tb_prbs7_gen.sv - directed self-checking bench for prbs7_gen (WORDWIDTH=16, SEED=7'h7F)

module tb_prbs7_gen;

    localparam int W = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prbs7_gen_if #(.WORDWIDTH(W)) bus ();

    prbs7_gen #(
        .WORDWIDTH (W),
        .SEED      (7'h7F)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    // Reference stream model: b[n] = b[n-6] ^ b[n-7], bits emitted LSB first.
    logic m_q[$];

    task automatic m_load(input logic [6:0] seed);
        m_q.delete();
        for (int i = 0; i < 7; i++) m_q.push_back(seed[i]);
    endtask

    task automatic m_next_word(output logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            w[i] = m_q[m_q.size()-6] ^ m_q[m_q.size()-7];
            m_q.push_back(w[i]);
        end
        while (m_q.size() > 7) void'(m_q.pop_front());
    endtask

    // Far-end checker prediction: next word from the previously received one.
    function automatic logic [W-1:0] chk_pred(input logic [W-1:0] prev);
        logic q[$];
        logic [W-1:0] w;
        for (int i = W-7; i < W; i++) q.push_back(prev[i]);
        for (int i = 0; i < W; i++) begin
            w[i] = q[q.size()-6] ^ q[q.size()-7];
            q.push_back(w[i]);
        end
        return w;
    endfunction

    logic [W-1:0] last_rx;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.en        = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed_in   = 7'h00;
`ifdef PRBS7GEN_ERRINJ_EN
        bus.inj_req   = 1'b0;
        bus.inj_bit   = '0;
`endif
    endtask

    task automatic do_reset;
        idle_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        n_vec++;
        if (bus.dout !== 16'h0000) begin
            n_err++; $display("FAIL reset_dout got=%h exp=%h", bus.dout, 16'h0000);
        end
        n_vec++;
        if (bus.dout_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got=%b exp=0", bus.dout_valid);
        end
        n_vec++;
        if (bus.word_cnt !== 16'h0000) begin
            n_err++; $display("FAIL reset_cnt got=%h exp=0000", bus.word_cnt);
        end
`ifdef PRBS7GEN_ERRINJ_EN
        n_vec++;
        if (bus.inj_ack !== 1'b0) begin
            n_err++; $display("FAIL reset_ack got=%b exp=0", bus.inj_ack);
        end
`endif
    endtask

    task automatic test_first_word;
        logic [W-1:0] exp;
        m_load(7'h7F);
        bus.en = 1'b1;
        tick();
        m_next_word(exp);
        n_vec++;
        if (bus.dout !== 16'h3040) begin
            n_err++; $display("FAIL first_word got=%h exp=3040", bus.dout);
        end
        n_vec++;
        if (bus.dout !== exp) begin
            n_err++; $display("FAIL first_word_model got=%h exp=%h", bus.dout, exp);
        end
        n_vec++;
        if (bus.dout[W-1:W-7] !== 7'h18) begin
            n_err++; $display("FAIL first_state got=%h exp=18", bus.dout[W-1:W-7]);
        end
        n_vec++;
        if (bus.dout_valid !== 1'b1 || bus.word_cnt !== 16'd1) begin
            n_err++; $display("FAIL first_valid_cnt got=%b/%h exp=1/0001", bus.dout_valid, bus.word_cnt);
        end
        last_rx = bus.dout;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] exp;
        logic [W-1:0] words[128];
        for (int k = 0; k < 128; k++) begin
            bus.en = 1'b1;
            tick();
            m_next_word(exp);
            words[k] = bus.dout;
            n_vec++;
            if (bus.dout !== exp || bus.dout_valid !== 1'b1) begin
                n_err++; $display("FAIL b2b_word%0d got=%h/%b exp=%h/1", k, bus.dout, bus.dout_valid, exp);
            end
            n_vec++;
            if (bus.dout !== chk_pred(last_rx)) begin
                n_err++; $display("FAIL b2b_checker%0d got=%h exp=%h", k, bus.dout, chk_pred(last_rx));
            end
            last_rx = bus.dout;
        end
        n_vec++;
        if (words[127] !== words[0]) begin
            n_err++; $display("FAIL b2b_period got=%h exp=%h", words[127], words[0]);
        end
        n_vec++;
        if (bus.word_cnt !== 16'd129) begin
            n_err++; $display("FAIL b2b_cnt got=%0d exp=129", bus.word_cnt);
        end
    endtask

    task automatic test_pause;
        logic [W-1:0] exp;
        logic [W-1:0] held;
        logic [15:0]  cnt;
        held = bus.dout;
        cnt  = bus.word_cnt;
        bus.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (bus.dout !== held || bus.dout_valid !== 1'b0 || bus.word_cnt !== cnt) begin
                n_err++; $display("FAIL pause%0d got=%h/%b/%h exp=%h/0/%h", k, bus.dout, bus.dout_valid, bus.word_cnt, held, cnt);
            end
        end
        bus.en = 1'b1;
        tick();
        m_next_word(exp);
        n_vec++;
        if (bus.dout !== exp || bus.dout_valid !== 1'b1 || bus.word_cnt !== cnt + 16'd1) begin
            n_err++; $display("FAIL resume got=%h/%b/%h exp=%h/1/%h", bus.dout, bus.dout_valid, bus.word_cnt, exp, cnt + 16'd1);
        end
        last_rx = bus.dout;
    endtask

    task automatic test_seed_load;
        logic [W-1:0] exp;
        logic [W-1:0] held;
        logic [15:0]  cnt;
        held = bus.dout;
        cnt  = bus.word_cnt;
        bus.en        = 1'b1;
        bus.seed_load = 1'b1;
        bus.seed_in   = 7'h00;
        tick();
        bus.seed_load = 1'b0;
        n_vec++;
        if (bus.dout !== held || bus.dout_valid !== 1'b0 || bus.word_cnt !== cnt) begin
            n_err++; $display("FAIL seed_cycle got=%h/%b/%h exp=%h/0/%h", bus.dout, bus.dout_valid, bus.word_cnt, held, cnt);
        end
        tick();
        n_vec++;
        if (bus.dout !== 16'h3040 || bus.dout_valid !== 1'b1) begin
            n_err++; $display("FAIL seed_zero_word got=%h/%b exp=3040/1", bus.dout, bus.dout_valid);
        end
        bus.en        = 1'b0;
        bus.seed_load = 1'b1;
        bus.seed_in   = 7'h18;
        tick();
        bus.seed_load = 1'b0;
        bus.en        = 1'b1;
        tick();
        m_load(7'h18);
        m_next_word(exp);
        n_vec++;
        if (bus.dout !== exp || bus.word_cnt !== cnt + 16'd2) begin
            n_err++; $display("FAIL seed_18_word got=%h/%h exp=%h/%h", bus.dout, bus.word_cnt, exp, cnt + 16'd2);
        end
        last_rx = bus.dout;
    endtask

`ifdef PRBS7GEN_ERRINJ_EN
    task automatic test_inject;
        logic [W-1:0] exp;
        bus.en      = 1'b0;
        bus.inj_req = 1'b1;
        bus.inj_bit = 4'd5;
        tick();
        bus.inj_req = 1'b0;
        bus.en      = 1'b1;
        tick();
        m_next_word(exp);
        n_vec++;
        if (bus.dout !== (exp ^ 16'h0020) || bus.inj_ack !== 1'b1) begin
            n_err++; $display("FAIL inj5 got=%h/%b exp=%h/1", bus.dout, bus.inj_ack, exp ^ 16'h0020);
        end
        n_vec++;
        if (bus.dout === chk_pred(last_rx)) begin
            n_err++; $display("FAIL inj5_checker got=%h exp=not %h", bus.dout, chk_pred(last_rx));
        end
        last_rx = bus.dout;
        tick();
        m_next_word(exp);
        n_vec++;
        if (bus.dout !== exp || bus.inj_ack !== 1'b0) begin
            n_err++; $display("FAIL inj5_after got=%h/%b exp=%h/0", bus.dout, bus.inj_ack, exp);
        end
        last_rx = bus.dout;
        tick();
        m_next_word(exp);
        n_vec++;
        if (bus.dout !== chk_pred(last_rx) || bus.dout !== exp) begin
            n_err++; $display("FAIL inj5_clean got=%h exp=%h", bus.dout, exp);
        end
        // Request on an emitting cycle applies to the following word.
        bus.inj_req = 1'b1;
        bus.inj_bit = 4'd3;
        tick();
        bus.inj_req = 1'b0;
        m_next_word(exp);
        n_vec++;
        if (bus.dout !== exp || bus.inj_ack !== 1'b0) begin
            n_err++; $display("FAIL inj3_same got=%h/%b exp=%h/0", bus.dout, bus.inj_ack, exp);
        end
        tick();
        m_next_word(exp);
        n_vec++;
        if (bus.dout !== (exp ^ 16'h0008) || bus.inj_ack !== 1'b1) begin
            n_err++; $display("FAIL inj3_next got=%h/%b exp=%h/1", bus.dout, bus.inj_ack, exp ^ 16'h0008);
        end
        // Second request while pending is ignored.
        bus.en      = 1'b0;
        bus.inj_req = 1'b1;
        bus.inj_bit = 4'd2;
        tick();
        bus.inj_bit = 4'd15;
        tick();
        bus.inj_req = 1'b0;
        bus.en      = 1'b1;
        tick();
        m_next_word(exp);
        n_vec++;
        if (bus.dout !== (exp ^ 16'h0004) || bus.inj_ack !== 1'b1) begin
            n_err++; $display("FAIL inj_ignore got=%h/%b exp=%h/1", bus.dout, bus.inj_ack, exp ^ 16'h0004);
        end
        tick();
        m_next_word(exp);
        n_vec++;
        if (bus.dout !== exp || bus.inj_ack !== 1'b0) begin
            n_err++; $display("FAIL inj_ignore_after got=%h/%b exp=%h/0", bus.dout, bus.inj_ack, exp);
        end
        bus.en = 1'b0;
        last_rx = bus.dout;
    endtask
`endif

    task automatic test_wrap;
        do_reset();
        bus.en = 1'b1;
        repeat (65535) tick();
        n_vec++;
        if (bus.word_cnt !== 16'hFFFF) begin
            n_err++; $display("FAIL wrap_pre got=%h exp=ffff", bus.word_cnt);
        end
        tick();
        n_vec++;
        if (bus.word_cnt !== 16'h0000 || bus.dout_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap got=%h/%b exp=0000/1", bus.word_cnt, bus.dout_valid);
        end
    endtask

    task automatic test_async_reset;
        bus.en = 1'b1;
        tick();
        #3;
        rstn = 1'b0;
        #1;
        n_vec++;
        if (bus.dout !== 16'h0000 || bus.dout_valid !== 1'b0 || bus.word_cnt !== 16'h0000) begin
            n_err++; $display("FAIL async_reset got=%h/%b/%h exp=0000/0/0000", bus.dout, bus.dout_valid, bus.word_cnt);
        end
        tick();
        rstn = 1'b1;
        tick();
        n_vec++;
        if (bus.dout !== 16'h3040 || bus.word_cnt !== 16'd1) begin
            n_err++; $display("FAIL post_reset_word got=%h/%h exp=3040/0001", bus.dout, bus.word_cnt);
        end
        bus.en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_back_to_back();
        test_pause();
        test_seed_load();
`ifdef PRBS7GEN_ERRINJ_EN
        test_inject();
`endif
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
